// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain stage: packet FSM encoding
// and output buffer depth.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MID  = 2'd1,
    LAST = 2'd2
  } pkt_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry in-order word buffer with simultaneous push/pop; head reads as zero
// when empty.
module fifo_rd_skid2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);
  import fifo_rd_stream_pkg::*;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else if (push && !pop) begin
      occ <= occ + 2'd1;
    end else if (pop && !push) begin
      occ <= occ - 2'd1;
    end
  end

  // Data slots carry no reset; stale contents are masked by occ.
  always_ff @(posedge clk) begin
    if (pop) begin
      slot0 <= (occ == 2'd1) ? din : slot1;
      if (push) slot1 <= din;
    end else if (push) begin
      if (occ == 2'd0) slot0 <= din;
      else             slot1 <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && occ == FULL));
      assert (!(pop && occ == 2'd0));
    end
  end

  assign head = (occ != 2'd0) ? slot0 : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: issues reads against a one-cycle-latency FIFO, buffers
// returned words and presents them as a packetised valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 4,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ERR_W-1:0]  err_count
);
  import fifo_rd_stream_pkg::*;

  localparam int               IDX_W      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PKT_LEN - 1);
  localparam pkt_state_t       WRAP_STATE = (PKT_LEN == 1) ? LAST : MID;

  logic [1:0]       occ;
  logic             pop;
  logic             inflight;
  logic [2:0]       committed;
  logic [2:0]       occ_after;
  logic [IDX_W-1:0] idx;
  pkt_state_t       state;

  assign m_valid   = (occ != 2'd0);
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (idx == LAST_IDX);

  // Words already buffered or still returning from the FIFO, net of this pop.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign occ_after = {1'b0, occ} + {2'b00, fifo_rd_ack} - {2'b00, pop};
  assign fifo_rd_en = !reset && !fifo_empty && (committed < 3'(BUF_DEPTH));

  fifo_rd_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk  (clk),
    .rst  (reset),
    .push (fifo_rd_ack),
    .din  (fifo_d_out),
    .pop  (pop),
    .occ  (occ),
    .head (m_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
    end else if (fifo_rd_en) begin
      inflight <= 1'b1;
    end else if (fifo_rd_ack || fifo_rd_err) begin
      inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (fifo_rd_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else if (pop) begin
      if (idx == LAST_IDX) begin
        idx   <= '0;
        state <= (occ_after != 3'd0) ? WRAP_STATE : IDLE;
      end else begin
        idx   <= idx + IDX_W'(1);
        state <= ((idx + IDX_W'(1)) == LAST_IDX) ? LAST : MID;
      end
    end else if (state == IDLE && m_valid) begin
      state <= WRAP_STATE;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural upstream FIFO plus a word-level
// reference of buffered words, packet position and error count.
module tb_fifo_rd_stream;
  localparam int DATA_W  = 32;
  localparam int PKT_LEN = 4;
  localparam int ERR_W   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_ack = 1'b0;
  logic              fifo_rd_err = 1'b0;
  logic [DATA_W-1:0] fifo_d_out = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic [ERR_W-1:0]  err_count;

  fifo_rd_stream #(
    .DATA_W  (DATA_W),
    .PKT_LEN (PKT_LEN),
    .ERR_W   (ERR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_ack (fifo_rd_ack),
    .fifo_rd_err (fifo_rd_err),
    .fifo_d_out  (fifo_d_out),
    .fifo_rd_en  (fifo_rd_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_buf[$];
  logic [DATA_W-1:0] emitted[$];
  logic [DATA_W-1:0] loaded[$];
  bit                lasts[$];
  int                pkt_idx = 0;
  int                err_total = 0;
  int                reads_issued = 0;
  bit                lag_mode = 1'b0;
  bit                force_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit rd_pre, ack_pre, err_pre, pop_pre, rst_pre, last_pre;
    logic [DATA_W-1:0] w_pre, m_pre;
    int sz_pre;
    #1;
    rd_pre   = fifo_rd_en;
    ack_pre  = fifo_rd_ack;
    err_pre  = fifo_rd_err;
    w_pre    = fifo_d_out;
    pop_pre  = m_valid && m_ready;
    rst_pre  = reset;
    m_pre    = m_data;
    last_pre = m_last;
    sz_pre   = fq.size();
    @(posedge clk);
    #1;
    fifo_rd_ack = 1'b0;
    fifo_rd_err = force_err;
    if (rd_pre) begin
      reads_issued++;
      if (fq.size() > 0) begin
        fifo_rd_ack = 1'b1;
        fifo_d_out  = fq.pop_front();
      end else begin
        fifo_rd_err = 1'b1;
      end
    end
    fifo_empty = lag_mode ? (sz_pre == 0) : (fq.size() == 0);
    if (rst_pre) begin
      exp_buf.delete();
      pkt_idx   = 0;
      err_total = 0;
    end else begin
      if (pop_pre) begin
        emitted.push_back(m_pre);
        lasts.push_back(last_pre);
        if (exp_buf.size() > 0) void'(exp_buf.pop_front());
        pkt_idx = (pkt_idx + 1) % PKT_LEN;
      end
      if (ack_pre) exp_buf.push_back(w_pre);
      if (err_pre && err_total < 255) err_total++;
    end
    #1;
    chk("m_valid", m_valid, exp_buf.size() != 0);
    chk("m_data", m_data, (exp_buf.size() != 0) ? exp_buf[0] : '0);
    chk("m_last", m_last, (exp_buf.size() != 0) && (pkt_idx == PKT_LEN - 1));
    chk("err_count", err_count, err_total);
    chk("no_overflow", exp_buf.size() <= 2, 1);
  endtask

  task automatic load(input logic [DATA_W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] w;

    // Reset with a nonempty FIFO: no reads may be issued.
    for (int i = 0; i < 8; i++) load(32'h10 + i);
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rd_en_in_reset", fifo_rd_en, 0);
    end
    reset = 1'b0;
    #1;
    chk("rd_en_after_reset", fifo_rd_en, 1);

    // Streaming at full rate with packet boundaries.
    step();
    chk("startup_not_yet", m_valid, 0);
    step();
    chk("startup_valid", m_valid, 1);
    n = 0;
    while (emitted.size() < 8 && n < 30) begin step(); n++; end
    chk("stream_timeout", emitted.size(), 8);
    for (int i = 0; i < 8 && i < emitted.size(); i++) begin
      chk("stream_word", emitted[i], 32'h10 + i);
      chk("stream_last", lasts[i], (i == 3) || (i == 7));
    end

    // Back-pressure: exactly two reads, head held.
    emitted.delete(); lasts.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(32'h20 + i);
    reads_issued = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) chk("stall_hold", m_data, 32'h20);
    end
    chk("stall_reads", reads_issued, 2);
    chk("stall_no_err", err_count, 0);
    m_ready = 1'b1;
    n = 0;
    while (emitted.size() < 6 && n < 40) begin step(); n++; end
    chk("stall_drain_timeout", emitted.size(), 6);
    for (int i = 0; i < 6 && i < emitted.size(); i++) chk("stall_word", emitted[i], 32'h20 + i);

    // Lagging empty flag: second back-to-back read errors.
    emitted.delete(); lasts.delete();
    lag_mode = 1'b1;
    load(32'h55);
    reads_issued = 0;
    for (int i = 0; i < 10; i++) step();
    lag_mode = 1'b0;
    chk("lag_err_count", err_count, 1);
    chk("lag_reads", reads_issued, 2);
    chk("lag_words", emitted.size(), 1);
    if (emitted.size() > 0) chk("lag_word", emitted[0], 32'h55);

    // Error counter saturation.
    force_err = 1'b1;
    for (int i = 0; i < 300; i++) step();
    force_err = 1'b0;
    step();
    chk("err_saturate", err_count, 255);

    // Reset mid-packet with a full buffer.
    emitted.delete(); lasts.delete();
    for (int i = 0; i < 12; i++) load(32'h30 + i);
    m_ready = 1'b1;
    n = 0;
    while (!(pkt_idx == 2 && exp_buf.size() == 2) && n < 40) begin
      step();
      if (pkt_idx == 2) m_ready = 1'b0;
      n++;
    end
    chk("prereset_timeout", (pkt_idx == 2) && (exp_buf.size() == 2), 1);
    chk("prereset_head", m_data, 32'h33);
    reset = 1'b1;
    step();
    chk("reset_flush", m_valid, 0);
    reset = 1'b0;
    emitted.delete(); lasts.delete();
    m_ready = 1'b1;
    n = 0;
    while (emitted.size() < 4 && n < 30) begin step(); n++; end
    chk("postreset_timeout", emitted.size() >= 4, 1);
    if (emitted.size() > 0) chk("fifo_kept", emitted[0], 32'h35);
    for (int i = 0; i < 4 && i < lasts.size(); i++) chk("postreset_last", lasts[i], i == 3);
    n = 0;
    while ((fq.size() > 0 || exp_buf.size() > 0 || fifo_rd_ack) && n < 40) begin step(); n++; end
    chk("drain_timeout", fq.size() + exp_buf.size(), 0);

    // Randomised traffic and back-pressure.
    emitted.delete(); lasts.delete();
    for (int i = 0; i < 400; i++) begin
      if (fq.size() < 8 && $urandom_range(2, 0) == 0) begin
        w = $urandom();
        loaded.push_back(w);
        load(w);
      end
      m_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    m_ready = 1'b1;
    n = 0;
    while ((fq.size() > 0 || exp_buf.size() > 0 || fifo_rd_ack) && n < 40) begin step(); n++; end
    chk("rand_count", emitted.size(), loaded.size());
    for (int i = 0; i < loaded.size() && i < emitted.size(); i++) chk("rand_word", emitted[i], loaded[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain stage placed directly downstream of the 32-bit 8-deep handshake FIFO. It issues rd_en to the FIFO and accounts for the FIFO's one-cycle registered read latency. Returned words go into a 2-entry output buffer. Words are presented on a valid/ready stream with a packet-boundary flag every PKT_LEN words. FIFO read errors are counted for status.

Parameters:
DATA_W, 32, width of FIFO data and stream data
PKT_LEN, 4, words per packet (legal 1..256); m_last asserts on the final word
ERR_W, 8, width of the saturating read-error counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_rd_ack  input  1  FIFO read acknowledge; fifo_d_out valid this cycle
fifo_rd_err  input  1  FIFO read error (read requested while empty)
fifo_d_out  input  DATA_W  FIFO read data
fifo_rd_en  output  1  read request to FIFO
m_data  output  DATA_W  stream data
m_valid  output  1  stream data valid
m_ready  input  1  downstream accepts when high with m_valid
m_last  output  1  last word of packet, qualified by m_valid
err_count  output  ERR_W  saturating count of fifo_rd_err pulses

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); its polarity and synchronicity are fixed. Reset has priority over all other events.
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, err_count=0.
  - Buffer occupancy occ=0, inflight=0, word index idx=0, state=IDLE.
- FIFO timing contract: rd_en sampled at edge t produces fifo_rd_ack or fifo_rd_err during cycle t+1, with data on fifo_d_out during that same cycle.
- Registers:
  - inflight (0/1): set when fifo_rd_en is issued; cleared on ack or err unless a new read is issued the same cycle. It never underflows.
- Issue rule (combinational fifo_rd_en):
  - fifo_rd_en = !reset && !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - Back-to-back reads are allowed, giving one word per cycle sustained.
- Capture:
  - On fifo_rd_ack, fifo_d_out is written to the buffer tail.
  - Push and pop may occur in the same cycle; occ is then unchanged and order is preserved.
  - The issue rule guarantees no overflow. Overflow is an assertion failure.
- Read error: fifo_rd_err (expected when the FIFO's empty flag lags a back-to-back read) captures no data. err_count increments and saturates at 2^ERR_W-1.
- Ack while inflight=0 (e.g. the cycle after reset): data is captured normally. The buffer is empty after reset, so it always has room.
- Output:
  - m_valid = (occ != 0); m_data = buffer head, held stable while m_valid && !m_ready.
  - m_data is 0 when occ=0.
- Packet FSM:
  - IDLE: idx=0, no word presented.
  - IDLE -> MID when m_valid rises.
  - MID -> LAST when idx reaches PKT_LEN-1.
  - Each pop increments idx; a pop in LAST resets idx=0 and returns to MID if occ stays nonzero, otherwise to IDLE.
  - m_last = m_valid && (idx == PKT_LEN-1). PKT_LEN=1 makes every word last.
- Reset mid-packet discards buffered words and restarts idx at 0. The FIFO keeps its own contents.

Decomposition:
- Shared package: FSM state encoding (IDLE, MID, LAST, 2 bits) and the buffer depth constant (2).
- One sub-module: fifo_rd_skid2, a 2-entry DATA_W buffer with push, pop, occ and head outputs, plus synchronous active-high reset.
- Issue logic, inflight tracking, error counter and packet FSM live in the top.

Test Plan:
- Reset for 2 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, err_count=0; first fifo_rd_en=1 in the cycle after reset drops.
- FIFO model holding 8 words 0x10..0x17, m_ready=1 -> m_data 0x10..0x17 in order at one per cycle after 2-cycle startup; m_last on 0x13 and 0x17.
- m_ready=0 for 10 cycles with FIFO nonempty -> exactly 2 reads issued, occ=2, m_data=first word held stable; no rd_err.
- FIFO holding 1 word, back-to-back rd_en hits the lagging empty flag -> model returns rd_err on the 2nd read; err_count=1; exactly one word emitted.
- 300 forced rd_err pulses with ERR_W=8 -> err_count saturates at 255.
- Reset asserted with occ=2 and idx=2 -> next cycle m_valid=0; the next emitted packet's m_last falls on its 4th word.
